// File: rtl/game_pkg.sv
// game_pkg
//   Shared constants for the game blocks: play-state encoding, default
//   starting health and the hit row shared by the collision detector and HUD.
package game_pkg;

  // Top-level play state. The encoding is fixed because the HUD decodes it.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_COOLDOWN  = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  // Default starting health. The top-level MAX_HEALTH parameter defaults to this.
  localparam int MAX_HEALTH_DEF = 3;

  // Screen row where a collision counts as a hit.
  localparam logic [7:0] HIT_Y = 8'd119;

endpackage

// File: rtl/health_manager_rise_edge_detect.sv
// rise_edge_detect
//   Registers the input each cycle and flags the cycle in which it goes
//   from low to high. A level held high gives exactly one rise. Reusable
//   for the start button and other inputs.
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active high; clears the history register
//     d    - level input
//     rise - d & ~d_prev (combinational from d, for use inside a
//            registered consumer)
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/health_manager.sv
// health_manager
//   Tracks player health from the collision flag, runs the play state
//   (idle / playing / cooldown / game over) and applies a post-hit
//   invulnerability window.
//   Ports:
//     clk           - system clock
//     rst           - synchronous reset, active high; overrides every input
//     start         - begin or restart a game (level-sampled in IDLE/GAME_OVER)
//     health_update - collision flag; only its rising edge counts as a hit
//     health        - current health for the HUD
//     hit_pulse     - one-cycle pulse per accepted hit
//     invulnerable  - high during the post-hit cooldown
//     playing       - high in PLAYING or COOLDOWN
//     game_over     - high in GAME_OVER (gates the enemy movers)
//   All outputs come from registers or from decoding the registered state.
module health_manager #(
  parameter int MAX_HEALTH      = game_pkg::MAX_HEALTH_DEF,
  parameter int HEALTH_W        = 2,
  parameter int COOLDOWN_CYCLES = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                health_update,
  output logic [HEALTH_W-1:0] health,
  output logic                hit_pulse,
  output logic                invulnerable,
  output logic                playing,
  output logic                game_over
);

  import game_pkg::*;

  localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] HEALTH_ONE  = HEALTH_W'(1);
  // The counter counts down to 0 inclusive, so loading N-1 gives N cycles.
  localparam logic [CNT_W-1:0]    CNT_LOAD    = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  state_e              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hit_q, hit_d;
  logic                rise;

  rise_edge_detect u_upd_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (health_update),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      health_q <= HEALTH_FULL;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A rise coinciding with start is deliberately dropped.
        if (start) begin
          health_d = HEALTH_FULL;
          state_d  = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (rise) begin
          hit_d = 1'b1;
          // <= rather than == so a zero health can never wrap around.
          if (health_q <= HEALTH_ONE) begin
            health_d = '0;
            state_d  = ST_GAME_OVER;
          end else begin
            health_d = health_q - HEALTH_ONE;
            cnt_d    = CNT_LOAD;
            state_d  = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        // The edge detector keeps tracking here, so a level still high on
        // exit cannot produce a hit until it falls and rises again.
        if (cnt_q == '0) state_d = ST_PLAYING;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_GAME_OVER: begin
        if (start) begin
          health_d = HEALTH_FULL;
          cnt_d    = '0;
          state_d  = ST_PLAYING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign health       = health_q;
  assign hit_pulse    = hit_q;
  assign invulnerable = (state_q == ST_COOLDOWN);
  assign playing      = (state_q == ST_PLAYING) || (state_q == ST_COOLDOWN);
  assign game_over    = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_health_manager.sv
// tb_health_manager
//   Scenario tasks drive {rst,start,health_update} one cycle at a time.
//   For every cycle the hand-derived expected outputs after that edge are
//   pushed to a scoreboard queue and popped/compared #1 after the edge.
module tb_health_manager;

  typedef struct packed {
    logic [1:0] h;
    logic       hit;
    logic       inv;
    logic       ply;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       health_update = 1'b0;
  logic [1:0] health;
  logic       hit_pulse, invulnerable, playing, game_over;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  health_manager #(
    .MAX_HEALTH      (3),
    .HEALTH_W        (2),
    .COOLDOWN_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .health_update (health_update),
    .health        (health),
    .hit_pulse     (hit_pulse),
    .invulnerable  (invulnerable),
    .playing       (playing),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  function automatic exp_t e(int h, bit hit, bit inv, bit ply, bit go);
    exp_t r;
    r.h = 2'(h); r.hit = hit; r.inv = inv; r.ply = ply; r.go = go;
    return r;
  endfunction

  // Stimulus word: {rst, start, health_update}
  task automatic test_reset();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b100, 3'b101, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000};
    ex   = '{e(3,0,0,0,0), e(3,0,0,0,0), e(3,0,0,0,0), e(3,0,0,0,0),
             e(3,0,0,0,0), e(3,0,0,0,0), e(3,0,0,0,0), e(3,0,0,0,0)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_start();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b010, 3'b000, 3'b000};
    ex   = '{e(3,0,0,1,0), e(3,0,0,1,0), e(3,0,0,1,0)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL start cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  // Level held 10 cycles: one hit, 4 cycles invulnerable, no re-hit.
  task automatic test_hold();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
             3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    ex   = '{e(2,1,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,0,1,0),
             e(2,0,0,1,0), e(2,0,0,1,0), e(2,0,0,1,0), e(2,0,0,1,0), e(2,0,0,1,0),
             e(2,0,0,1,0)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  // Hit 2->1, new rise at cooldown cycle 2 ignored, then fatal hit and
  // rises in GAME_OVER ignored.
  task automatic test_cooldown_rise();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b000, 3'b001, 3'b000};
    ex   = '{e(1,1,1,1,0), e(1,0,1,1,0), e(1,0,1,1,0), e(1,0,1,1,0), e(1,0,0,1,0),
             e(1,0,0,1,0), e(0,1,0,0,1), e(0,0,0,0,1), e(0,0,0,0,1), e(0,0,0,0,1)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cooldown_rise cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  // Restart from GAME_OVER, three separated hits 3->2->1->0 with a start
  // in PLAYING in between (ignored), then rises after game over.
  task automatic test_three_hits();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b010, 3'b000,
             3'b001, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b010, 3'b000,
             3'b001, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b000, 3'b001, 3'b000};
    ex   = '{e(3,0,0,1,0), e(3,0,0,1,0),
             e(2,1,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,0,1,0),
             e(2,0,0,1,0), e(2,0,0,1,0),
             e(1,1,1,1,0), e(1,0,1,1,0), e(1,0,1,1,0), e(1,0,1,1,0), e(1,0,0,1,0),
             e(0,1,0,0,1), e(0,0,0,0,1), e(0,0,0,0,1), e(0,0,0,0,1)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL three_hits cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  // Reach COOLDOWN with health=1, then rst together with start and a rise.
  task automatic test_reset_cooldown();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b010,
             3'b001, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b000,
             3'b111, 3'b001, 3'b000};
    ex   = '{e(3,0,0,1,0),
             e(2,1,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,1,1,0), e(2,0,0,1,0),
             e(1,1,1,1,0), e(1,0,1,1,0),
             e(3,0,0,0,0), e(3,0,0,0,0), e(3,0,0,0,0)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_cooldown cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  // Start coinciding with a rise in IDLE: game starts, rise dropped, and
  // the still-high level produces no later hit.
  task automatic test_start_with_rise();
    logic [2:0] stim[$];
    exp_t ex[$];
    exp_t got, want;
    stim = '{3'b011, 3'b001, 3'b001, 3'b000, 3'b001};
    ex   = '{e(3,0,0,1,0), e(3,0,0,1,0), e(3,0,0,1,0), e(3,0,0,1,0), e(2,1,1,1,0)};
    foreach (stim[i]) begin
      {rst, start, health_update} = stim[i];
      sbq.push_back(ex[i]);
      @(posedge clk); #1;
      got = '{health, hit_pulse, invulnerable, playing, game_over};
      want = sbq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL start_with_rise cyc %0d got {h,hit,inv,ply,go}=%b required %b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hold();
    test_cooldown_rise();
    test_three_hits();
    test_reset_cooldown();
    test_start_with_rise();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/health_manager.md
Name: health_manager

Overview:
- Consumes the one-bit `health_update` collision flag and maintains the player's health count.
- Rising-edge detects hits and decrements health; applies a post-hit invulnerability cooldown.
- Runs the top-level play state (idle / playing / cooldown / game over).
- Outputs drive the HUD health display, the hit flash effect, and game-over gating of the enemy movers.

Parameters:
- MAX_HEALTH, 3, health loaded on reset and on start.
- HEALTH_W, 2, width of the health counter; must hold MAX_HEALTH.
- COOLDOWN_CYCLES, 25000000, invulnerability length in clk cycles after a non-fatal hit (0.5 s at 50 MHz). Must be ≥1.
- CNT_W, 25, width of the cooldown counter; must hold COOLDOWN_CYCLES-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin or restart a game; level-sampled.
- health_update  input  1  collision flag from the collision detector; may stay high for many cycles.
- health  output  HEALTH_W  current health.
- hit_pulse  output  1  one-cycle pulse for each accepted hit.
- invulnerable  output  1  high while in COOLDOWN.
- playing  output  1  high in PLAYING or COOLDOWN.
- game_over  output  1  high in GAME_OVER.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, health=MAX_HEALTH.
  - cooldown counter=0, upd_prev=0.
  - hit_pulse=0, invulnerable=0, playing=0, game_over=0.
  - rst has priority over every other input.
- Edge detect:
  - upd_prev registers health_update every cycle in all states.
  - rise = health_update & ~upd_prev.
  - A level held high yields exactly one rise.
- IDLE:
  - start=1 → health=MAX_HEALTH, go to PLAYING.
  - rise is ignored, including when it coincides with start.
- PLAYING, on rise:
  - hit_pulse=1 for the next cycle only.
  - If health==1: health=0, go to GAME_OVER.
  - Else: health=health-1, counter=COOLDOWN_CYCLES-1, go to COOLDOWN.
  - start is ignored in PLAYING.
- Latency: health, state and hit_pulse change at the clk edge that samples the rise. They are visible one cycle after health_update first goes high.
- COOLDOWN:
  - rise is ignored; no decrement and no pulse.
  - Counter decrements each cycle. At the edge where counter==0, go to PLAYING.
  - Total COOLDOWN duration is exactly COOLDOWN_CYCLES cycles.
  - If health_update is still high on exit, no hit occurs until it falls and rises again.
- GAME_OVER:
  - health holds at 0; rise is ignored.
  - start=1 → health=MAX_HEALTH, counter=0, go to PLAYING.
- Health never underflows; a decrement happens only when health≥1.
- Output decode:
  - invulnerable = (state==COOLDOWN).
  - playing = (state==PLAYING or COOLDOWN).
  - game_over = (state==GAME_OVER).
  - All outputs are registered or decoded from registered state; none depend combinationally on inputs.
- Reset mid-cooldown or mid-game returns to IDLE with full health on the next edge; no hit_pulse is emitted.

Decomposition:
- Shared package (game_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_PLAYING=2'd1, ST_COOLDOWN=2'd2, ST_GAME_OVER=2'd3.
  - MAX_HEALTH default.
  - HIT_Y=8'd119, so the collision detector and HUD share the same value.
- One natural sub-module: rise_edge_detect.
  - Ports: clk, rst, d, rise.
  - Contains the upd_prev register; reusable for the start button and other inputs.
- FSM, health counter and cooldown counter stay in health_manager.

Test Plan (COOLDOWN_CYCLES=4, MAX_HEALTH=3):
- Reset then start=1 for 1 cycle → playing=1, health=3, game_over=0; health_update pulses before start caused no change.
- health_update high for 10 cycles in PLAYING → exactly one hit_pulse. Health 3→2 one cycle after the rise, invulnerable=1 for exactly 4 cycles, then PLAYING with health=2 and no second hit while the level stays high.
- New rise during cooldown (fall then rise at cooldown cycle 2) → no decrement, no hit_pulse; health stays 2.
- Three separated hits (each after cooldown ends) → health 3→2→1→0. The third hit goes directly to GAME_OVER with no cooldown; further rises leave health=0.
- In GAME_OVER, assert start → health=3, PLAYING next cycle. start asserted during PLAYING has no effect.
- rst=1 asserted during COOLDOWN with health=1 → next cycle state IDLE, health=3, all flags 0. start asserted in the same cycle as rst is ignored.
